seven_seg_scanner: RTL and testbench

Time-multiplexed digit scanner that sits directly upstream of the 4-bit-to-seven-segment decoder. It holds a multi-digit hex value and drives one nibble at a time on w,x,y,z into the decoder. It also drives the matching active-low digit enable, with a dead-time between digits to prevent ghosting. New values are taken tear-free at frame boundaries, and optional leading-zero blanking is supported.

---
 rtl/seven_seg_scanner.sv | 108 ++++++++++
 tb/tb_seven_seg_scanner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - time-multiplexed hex digit scanner with dead-time, frame-boundary commit and leading-zero blanking

module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 50000,
    parameter int DEAD_CYCLES    = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    lz_blank,
    output logic                    w,
    output logic                    x,
    output logic                    y,
    output logic                    z,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    updated
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic [VAL_W-1:0]      disp, disp_nx;
    logic [VAL_W-1:0]      pend, pend_nx;
    logic                  pend_valid, pend_valid_nx;
    logic [3:0]            nibble, nibble_nx;
    logic [NUM_DIGITS-1:0] en_n, en_n_nx;
    logic                  updated_q, updated_nx;
    logic [NUM_DIGITS-1:0] blank_nx;
    logic                  slot_end, frame_end, zeros_above;

    // Outputs are derived from next-state values so they line up with cnt/idx.
    always_comb begin
        slot_end      = (cnt == CNT_LAST);
        frame_end     = slot_end && (idx == IDX_LAST);
        cnt_nx        = slot_end ? '0 : cnt + 1'b1;
        idx_nx        = idx;
        if (slot_end) begin
            idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end

        disp_nx       = disp;
        pend_nx       = pend;
        pend_valid_nx = pend_valid;
        updated_nx    = 1'b0;
        if (frame_end && load) begin
            disp_nx       = value;
            pend_valid_nx = 1'b0;
            updated_nx    = 1'b1;
        end else if (frame_end && pend_valid) begin
            disp_nx       = pend;
            pend_valid_nx = 1'b0;
            updated_nx    = 1'b1;
        end else if (load) begin
            pend_nx       = value;
            pend_valid_nx = 1'b1;
        end

        // A digit is blank when it and every more significant nibble are zero.
        zeros_above = 1'b1;
        blank_nx    = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zeros_above = zeros_above && (disp_nx[4*k +: 4] == 4'h0);
            blank_nx[k] = lz_blank && zeros_above;
        end

        nibble_nx = disp_nx[4*int'(idx_nx) +: 4];
        en_n_nx   = '1;
        if ((cnt_nx >= DEAD_END) && !blank_nx[idx_nx]) begin
            en_n_nx[idx_nx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            nibble     <= 4'h0;
            en_n       <= '1;
            updated_q  <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            disp       <= disp_nx;
            pend       <= pend_nx;
            pend_valid <= pend_valid_nx;
            nibble     <= nibble_nx;
            en_n       <= en_n_nx;
            updated_q  <= updated_nx;
        end
    end

    assign {w, x, y, z} = nibble;
    assign digit_en_n   = en_n;
    assign updated      = updated_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner

module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic        lz_blank = 1'b0;
    logic        w, x, y, z;
    logic [3:0]  digit_en_n;
    logic        updated;

    int errors = 0;
    int checks = 0;

    seven_seg_scanner #(
        .NUM_DIGITS(4),
        .REFRESH_CYCLES(8),
        .DEAD_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .value(value),
        .lz_blank(lz_blank),
        .w(w),
        .x(x),
        .y(y),
        .z(z),
        .digit_en_n(digit_en_n),
        .updated(updated)
    );

    always #5 clk = ~clk;

    // Expected enables for cycle c (cycle 0 = first cycle after reset release).
    function automatic logic [3:0] exp_en(input int c, input logic [15:0] d, input logic lz);
        int   s = (c / 8) % 4;
        int   cc = c % 8;
        logic blank = lz && (s > 0);
        for (int k = s; k < 4; k++) begin
            if (d[k*4 +: 4] != 4'h0) blank = 1'b0;
        end
        if (cc < 2 || blank) return 4'hF;
        return ~(4'b0001 << s);
    endfunction

    function automatic logic [3:0] exp_nib(input int c, input logic [15:0] d);
        int s = (c / 8) % 4;
        return d[s*4 +: 4];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load = 1'b0;
        value = 16'h0;
        lz_blank = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (digit_en_n !== 4'hF) begin errors++; $display("FAIL reset_en got=%h want=f", digit_en_n); end
        checks++;
        if ({w, x, y, z} !== 4'h0) begin errors++; $display("FAIL reset_wxyz got=%h want=0", {w, x, y, z}); end
        checks++;
        if (updated !== 1'b0) begin errors++; $display("FAIL reset_updated got=%b want=0", updated); end
    endtask

    task automatic test_scan();
        do_reset();
        for (int c = 0; c < 64; c++) begin
            checks++;
            if (digit_en_n !== exp_en(c, 16'h0, 1'b0)) begin
                errors++; $display("FAIL scan_en c=%0d got=%b want=%b", c, digit_en_n, exp_en(c, 16'h0, 1'b0));
            end
            checks++;
            if ({w, x, y, z} !== 4'h0 || updated !== 1'b0) begin
                errors++; $display("FAIL scan_wxyz_upd c=%0d got=%h/%b want=0/0", c, {w, x, y, z}, updated);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tear_free();
        logic [15:0] d;
        do_reset();
        for (int c = 0; c < 64; c++) begin
            d = (c < 32) ? 16'h0 : 16'h1234;
            checks++;
            if ({w, x, y, z} !== exp_nib(c, d)) begin
                errors++; $display("FAIL tear_wxyz c=%0d got=%h want=%h", c, {w, x, y, z}, exp_nib(c, d));
            end
            checks++;
            if (digit_en_n !== exp_en(c, d, 1'b0)) begin
                errors++; $display("FAIL tear_en c=%0d got=%b want=%b", c, digit_en_n, exp_en(c, d, 1'b0));
            end
            checks++;
            if (updated !== (c == 32)) begin
                errors++; $display("FAIL tear_updated c=%0d got=%b want=%b", c, updated, c == 32);
            end
            load = (c == 10);
            value = (c == 10) ? 16'h1234 : 16'h0;
            @(negedge clk);
        end
    endtask

    task automatic test_overwrite();
        logic [15:0] d;
        int pulses = 0;
        do_reset();
        for (int c = 0; c < 64; c++) begin
            d = (c < 32) ? 16'h0 : 16'h0BCD;
            if (updated === 1'b1) pulses++;
            checks++;
            if ({w, x, y, z} !== exp_nib(c, d)) begin
                errors++; $display("FAIL overwrite_wxyz c=%0d got=%h want=%h", c, {w, x, y, z}, exp_nib(c, d));
            end
            load = (c == 5) || (c == 20);
            value = (c == 5) ? 16'hAAAA : (c == 20) ? 16'h0BCD : 16'h0;
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL overwrite_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_lz_blank();
        logic [15:0] d;
        logic        lz;
        do_reset();
        lz_blank = 1'b1;
        for (int c = 0; c < 128; c++) begin
            d = (c < 32) ? 16'h0 : (c < 64) ? 16'h0005 : 16'h0100;
            lz = (c < 96);
            if (c == 0) lz = 1'b0;
            checks++;
            if (digit_en_n !== exp_en(c, d, lz)) begin
                errors++; $display("FAIL lz_en c=%0d got=%b want=%b", c, digit_en_n, exp_en(c, d, lz));
            end
            checks++;
            if ({w, x, y, z} !== exp_nib(c, d)) begin
                errors++; $display("FAIL lz_wxyz c=%0d got=%h want=%h", c, {w, x, y, z}, exp_nib(c, d));
            end
            load = (c == 3) || (c == 40);
            value = (c == 3) ? 16'h0005 : (c == 40) ? 16'h0100 : 16'h0;
            if (c == 95) lz_blank = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        do_reset();
        for (int c = 0; c < 96; c++) begin
            d = (c < 32) ? 16'h0 : 16'h9876;
            checks++;
            if (updated !== (c == 32)) begin
                errors++; $display("FAIL edge_updated c=%0d got=%b want=%b", c, updated, c == 32);
            end
            checks++;
            if ({w, x, y, z} !== exp_nib(c, d)) begin
                errors++; $display("FAIL edge_wxyz c=%0d got=%h want=%h", c, {w, x, y, z}, exp_nib(c, d));
            end
            load = (c == 31);
            value = (c == 31) ? 16'h9876 : 16'h0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 52; c++) begin
            load = (c == 0) || (c == 40);
            value = (c == 0) ? 16'h1234 : (c == 40) ? 16'h5678 : 16'h0;
            @(negedge clk);
        end
        checks++;
        if (digit_en_n !== 4'b1011 || {w, x, y, z} !== 4'h2) begin
            errors++; $display("FAIL mid_pre got=%b/%h want=1011/2", digit_en_n, {w, x, y, z});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (digit_en_n !== 4'hF || {w, x, y, z} !== 4'h0 || updated !== 1'b0) begin
            errors++; $display("FAIL mid_async got=%b/%h/%b want=1111/0/0", digit_en_n, {w, x, y, z}, updated);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 64; c++) begin
            checks++;
            if ({w, x, y, z} !== 4'h0 || updated !== 1'b0) begin
                errors++; $display("FAIL mid_post c=%0d got=%h/%b want=0/0", c, {w, x, y, z}, updated);
            end
            checks++;
            if (digit_en_n !== exp_en(c, 16'h0, 1'b0)) begin
                errors++; $display("FAIL mid_post_en c=%0d got=%b want=%b", c, digit_en_n, exp_en(c, 16'h0, 1'b0));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_overwrite();
        test_lz_blank();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
